// File: rtl/pattern_ddr3_loader.sv
// pattern_ddr3_loader
// Packs a 1-bit-per-pixel pattern, arriving as a 32-bit word stream, into
// 256-bit DDR3 words. The body is written starting at base+1. The 256-bit
// header is written at base only after the whole body has been accepted, so a
// reader that polls the header never sees a valid header over a partial body.
module pattern_ddr3_loader #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 256
) (
    input  logic                  ddr_emif_clk,
    input  logic                  ddr_emif_rst,
    input  logic                  cfg_start,
    input  logic [11:0]           cfg_h_pix,
    input  logic [11:0]           cfg_v_pix,
    input  logic [31:0]           cfg_pat_num,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  ddr_emif_ready,
    output logic                  ddr_emif_write,
    output logic                  ddr_emif_read,
    output logic [ADDR_W-1:0]     ddr_emif_addr,
    output logic [DATA_W-1:0]     ddr_emif_write_data,
    output logic [DATA_W/8-1:0]   ddr_emif_byte_enable,
    output logic [4:0]            ddr_emif_burst_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Number of 32-bit input slots in one EMIF word.
    localparam int LANES = DATA_W / 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CALC      = 3'd1;
    localparam logic [2:0] ST_BODY_FILL = 3'd2;
    localparam logic [2:0] ST_BODY_WR   = 3'd3;
    localparam logic [2:0] ST_HEADER_WR = 3'd4;

    logic [2:0]          state_q,      state_d;
    logic [11:0]         h_q,          h_d;
    logic [11:0]         v_q,          v_d;
    logic [31:0]         pat_q,        pat_d;
    logic [ADDR_W-1:0]   base_q,       base_d;
    logic [23:0]         total_q,      total_d;
    logic [19:0]         in_rem_q,     in_rem_d;
    logic [16:0]         body_words_q, body_words_d;
    logic [ADDR_W-1:0]   wr_addr_q,    wr_addr_d;
    logic [2:0]          slot_q,       slot_d;
    logic                err_q,        err_d;
    logic                done_q,       done_d;

    logic [31:0]         lane_q [LANES];

    logic                in_xfer;
    logic                wr_acc;
    logic [23:0]         prod;
    logic                last_word;
    logic [4:0]          tail_bits;
    logic [31:0]         in_mask;
    logic [ADDR_W-1:0]   start_addr;
    logic [ADDR_W-1:0]   end_addr;
    logic [DATA_W-1:0]   body_word;
    logic [DATA_W-1:0]   header_word;

    assign in_xfer = in_valid && in_ready;
    assign wr_acc  = ddr_emif_write && ddr_emif_ready;

    // 12x12 product always fits in 24 bits; evaluated from the latched sizes.
    assign prod = 24'(h_q) * 24'(v_q);

    // The final input word may carry fewer than 32 valid pixels; its unused
    // low bits are forced to zero so stale bits never reach DDR3.
    assign last_word = (in_rem_q == 20'd1);
    assign tail_bits = total_q[4:0];
    assign in_mask   = (last_word && (tail_bits != 5'd0)) ?
                       ~(32'hFFFF_FFFF >> tail_bits) : 32'hFFFF_FFFF;

    assign start_addr = base_q + ADDR_W'(1);
    assign end_addr   = base_q + ADDR_W'(body_words_q);

    // Body word: slot 0 occupies the most significant 32 bits.
    always_comb begin
        body_word = '0;
        for (int i = 0; i < LANES; i++) begin
            body_word[DATA_W-1-32*i -: 32] = lane_q[i];
        end
    end

    // Header fields are 32 bits each, MSB-first, narrower values zero-extended.
    assign header_word = {32'(h_q),
                          32'(v_q),
                          32'(total_q),
                          pat_q,
                          32'(body_words_q),
                          32'(start_addr),
                          32'(end_addr),
                          32'd0};

    // Next-state and datapath control for the load sequence.
    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        pat_d        = pat_q;
        base_d       = base_q;
        total_d      = total_q;
        in_rem_d     = in_rem_q;
        body_words_d = body_words_q;
        wr_addr_d    = wr_addr_q;
        slot_d       = slot_q;
        err_d        = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    h_d    = cfg_h_pix;
                    v_d    = cfg_v_pix;
                    pat_d  = cfg_pat_num;
                    base_d = cfg_base_addr;
                    if ((cfg_h_pix == 12'd0) || (cfg_v_pix == 12'd0)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                total_d      = prod;
                in_rem_d     = 20'(({1'b0, prod} + 25'd31) >> 5);
                body_words_d = 17'(({1'b0, prod} + 25'd255) >> 8);
                wr_addr_d    = base_q + ADDR_W'(1);
                slot_d       = 3'd0;
                state_d      = ST_BODY_FILL;
            end

            ST_BODY_FILL: begin
                if (in_xfer) begin
                    slot_d   = slot_q + 3'd1;
                    in_rem_d = in_rem_q - 20'd1;
                    if ((slot_q == 3'd7) || last_word) begin
                        state_d = ST_BODY_WR;
                    end
                end
            end

            ST_BODY_WR: begin
                if (wr_acc) begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    slot_d    = 3'd0;
                    state_d   = (in_rem_q == 20'd0) ? ST_HEADER_WR : ST_BODY_FILL;
                end
            end

            ST_HEADER_WR: begin
                if (wr_acc) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and configuration registers.
    always_ff @(posedge ddr_emif_clk) begin
        if (ddr_emif_rst) begin
            state_q      <= ST_IDLE;
            h_q          <= '0;
            v_q          <= '0;
            pat_q        <= '0;
            base_q       <= '0;
            total_q      <= '0;
            in_rem_q     <= '0;
            body_words_q <= '0;
            wr_addr_q    <= '0;
            slot_q       <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            pat_q        <= pat_d;
            base_q       <= base_d;
            total_q      <= total_d;
            in_rem_q     <= in_rem_d;
            body_words_q <= body_words_d;
            wr_addr_q    <= wr_addr_d;
            slot_q       <= slot_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    // Pack register: one 32-bit lane per slot, cleared once its word is written.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        always_ff @(posedge ddr_emif_clk) begin
            if (ddr_emif_rst) begin
                lane_q[gi] <= '0;
            end else if ((state_q == ST_BODY_WR) && wr_acc) begin
                lane_q[gi] <= '0;
            end else if (in_xfer && (slot_q == 3'(gi))) begin
                lane_q[gi] <= in_data & in_mask;
            end
        end
    end

    // Outputs derive from registered state only, so address and data stay
    // stable while the EMIF stalls.
    assign in_ready             = (state_q == ST_BODY_FILL);
    assign ddr_emif_write       = (state_q == ST_BODY_WR) || (state_q == ST_HEADER_WR);
    assign ddr_emif_read        = 1'b0;
    assign ddr_emif_addr        = (state_q == ST_HEADER_WR) ? base_q : wr_addr_q;
    assign ddr_emif_write_data  = (state_q == ST_HEADER_WR) ? header_word : body_word;
    assign ddr_emif_byte_enable = {(DATA_W/8){ddr_emif_write}};
    assign ddr_emif_burst_count = 5'd1;
    assign busy                 = (state_q != ST_IDLE);
    assign done                 = done_q;
    assign err                  = err_q;

endmodule

// File: tb/tb_pattern_ddr3_loader.sv
// Directed testbench for pattern_ddr3_loader: single-word, partial, two-word
// (with address wrap), EMIF backpressure, zero-size reject and mid-load reset.
`timescale 1ns/1ps
module tb_pattern_ddr3_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [11:0]   cfg_h_pix;
    logic [11:0]   cfg_v_pix;
    logic [31:0]   cfg_pat_num;
    logic [21:0]   cfg_base_addr;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          emif_ready;
    logic          emif_write;
    logic          emif_read;
    logic [21:0]   emif_addr;
    logic [255:0]  emif_wdata;
    logic [31:0]   emif_be;
    logic [4:0]    emif_burst;
    logic          busy;
    logic          done;
    logic          err;

    int            vectors = 0;
    int            miscompares = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    logic [21:0]   acc_addr [$];
    logic [255:0]  acc_data [$];
    logic [31:0]   feed_q [$];

    always #5 clk = ~clk;

    pattern_ddr3_loader #(.ADDR_W(22), .DATA_W(256)) dut (
        .ddr_emif_clk         (clk),
        .ddr_emif_rst         (rst),
        .cfg_start            (cfg_start),
        .cfg_h_pix            (cfg_h_pix),
        .cfg_v_pix            (cfg_v_pix),
        .cfg_pat_num          (cfg_pat_num),
        .cfg_base_addr        (cfg_base_addr),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .ddr_emif_ready       (emif_ready),
        .ddr_emif_write       (emif_write),
        .ddr_emif_read        (emif_read),
        .ddr_emif_addr        (emif_addr),
        .ddr_emif_write_data  (emif_wdata),
        .ddr_emif_byte_enable (emif_be),
        .ddr_emif_burst_count (emif_burst),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    // Record every accepted EMIF write and every done/err pulse.
    always @(negedge clk) begin
        if (emif_write && emif_ready) begin
            acc_addr.push_back(emif_addr);
            acc_data.push_back(emif_wdata);
            $display("EMIF write addr=%h be=%h data=%h", emif_addr, emif_be, emif_wdata);
        end
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    function automatic logic [255:0] hdr(input logic [31:0] h, input logic [31:0] v,
                                         input logic [31:0] total, input logic [31:0] pat,
                                         input logic [31:0] fill, input logic [31:0] st,
                                         input logic [31:0] en);
        return {h, v, total, pat, fill, st, en, 32'd0};
    endfunction

    // Called at posedge+1; returns at posedge+1 one cycle later.
    task automatic start_load(input logic [11:0] h, input logic [11:0] v,
                              input logic [31:0] pat, input logic [21:0] base);
        cfg_h_pix     = h;
        cfg_v_pix     = v;
        cfg_pat_num   = pat;
        cfg_base_addr = base;
        cfg_start     = 1'b1;
        @(posedge clk); #1;
        cfg_start     = 1'b0;
    endtask

    // Offers feed_q word by word; returns at posedge+1 after the last accept.
    task automatic feed(output bit ok);
        int i = 0;
        int guard = 0;
        while (i < feed_q.size() && guard < 2000) begin
            in_valid = 1'b1;
            in_data  = feed_q[i];
            @(negedge clk);
            if (in_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        ok = (i == feed_q.size());
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (emif_write !== 1'b0 || emif_read !== 1'b0 || in_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got wr=%b rd=%b rdy=%b busy=%b done=%b err=%b required all 0",
                     emif_write, emif_read, in_ready, busy, done, err);
        end
        vectors++;
        if (emif_burst !== 5'd1 || emif_be !== 32'd0 || emif_addr !== 22'd0 || emif_wdata !== 256'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got burst=%0d be=%h addr=%h data=%h required burst=1 rest 0",
                     emif_burst, emif_be, emif_addr, emif_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_single_word;
        bit ok;
        int d0 = done_cnt;
        logic [255:0] exp_body = {32'hA5A5A5A5, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        logic [255:0] exp_hdr  = hdr(16, 16, 256, 32'h11, 1, 32'h101, 32'h101);
        acc_addr.delete(); acc_data.delete();
        start_load(12'd16, 12'd16, 32'h11, 22'h100);
        feed_q = {32'hA5A5A5A5, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        feed(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_feed: got not all 8 words accepted, required 8"); end
        vectors++;
        if (emif_write !== 1'b1 || emif_addr !== 22'h101) begin
            miscompares++;
            $display("FAIL single_latency: got wr=%b addr=%h required wr=1 addr=101", emif_write, emif_addr);
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_done: got no done pulse, required one"); end
        vectors++;
        if (acc_addr.size() != 2) begin
            miscompares++;
            $display("FAIL single_count: got %0d writes required 2", acc_addr.size());
        end else begin
            vectors++;
            if (acc_addr[0] !== 22'h101 || acc_data[0] !== exp_body) begin
                miscompares++;
                $display("FAIL single_body: got addr=%h data=%h required addr=101 data=%h", acc_addr[0], acc_data[0], exp_body);
            end
            vectors++;
            if (acc_addr[1] !== 22'h100 || acc_data[1] !== exp_hdr) begin
                miscompares++;
                $display("FAIL single_header: got addr=%h data=%h required addr=100 data=%h", acc_addr[1], acc_data[1], exp_hdr);
            end
        end
        vectors++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pulse: got done_count=%0d busy=%b required 1 and 0", done_cnt - d0, busy);
        end
        $display("test_single_word done");
    endtask

    task automatic test_partial;
        bit ok;
        logic [255:0] exp_body = {32'hFFFFF000, 224'd0};
        logic [255:0] exp_hdr  = hdr(20, 1, 20, 32'h22, 1, 32'h201, 32'h201);
        acc_addr.delete(); acc_data.delete();
        start_load(12'd20, 12'd1, 32'h22, 22'h200);
        feed_q = {32'hFFFFF000};
        feed(ok);
        wait_done(ok);
        vectors++;
        if (!ok || acc_addr.size() != 2) begin
            miscompares++;
            $display("FAIL partial_count: got done=%b writes=%0d required done and 2 writes", ok, acc_addr.size());
        end else begin
            vectors++;
            if (acc_addr[0] !== 22'h201 || acc_data[0] !== exp_body) begin
                miscompares++;
                $display("FAIL partial_body: got addr=%h data=%h required addr=201 data=%h", acc_addr[0], acc_data[0], exp_body);
            end
            vectors++;
            if (acc_addr[1] !== 22'h200 || acc_data[1] !== exp_hdr) begin
                miscompares++;
                $display("FAIL partial_header: got addr=%h data=%h required addr=200 data=%h", acc_addr[1], acc_data[1], exp_hdr);
            end
        end
        $display("test_partial done");
    endtask

    // 288 pixels -> 9 input words -> 2 body words; base at top of the address space wraps.
    task automatic test_two_words;
        bit ok;
        logic [255:0] exp0 = {32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                              32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007};
        logic [255:0] exp1 = {32'h10000008, 224'd0};
        logic [255:0] exp_hdr = hdr(32, 9, 288, 32'h33, 2, 32'h000000, 32'h000001);
        acc_addr.delete(); acc_data.delete();
        start_load(12'd32, 12'd9, 32'h33, 22'h3FFFFF);
        feed_q.delete();
        for (int i = 0; i < 9; i++) feed_q.push_back(32'h10000000 + 32'(i));
        feed(ok);
        wait_done(ok);
        vectors++;
        if (!ok || acc_addr.size() != 3) begin
            miscompares++;
            $display("FAIL two_count: got done=%b writes=%0d required done and 3 writes", ok, acc_addr.size());
        end else begin
            vectors++;
            if (acc_addr[0] !== 22'h000000 || acc_data[0] !== exp0) begin
                miscompares++;
                $display("FAIL two_body0: got addr=%h data=%h required addr=000000 data=%h", acc_addr[0], acc_data[0], exp0);
            end
            vectors++;
            if (acc_addr[1] !== 22'h000001 || acc_data[1] !== exp1) begin
                miscompares++;
                $display("FAIL two_body1: got addr=%h data=%h required addr=000001 data=%h", acc_addr[1], acc_data[1], exp1);
            end
            vectors++;
            if (acc_addr[2] !== 22'h3FFFFF || acc_data[2] !== exp_hdr) begin
                miscompares++;
                $display("FAIL two_header: got addr=%h data=%h required addr=3fffff data=%h", acc_addr[2], acc_data[2], exp_hdr);
            end
        end
        $display("test_two_words done");
    endtask

    // Stall BODY_WR and HEADER_WR for 5 cycles each; a cfg_start during the stall is ignored.
    task automatic test_backpressure;
        bit ok;
        int d0 = done_cnt;
        logic [255:0] exp_body = {32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                                  32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
        logic [255:0] exp_hdr = hdr(16, 16, 256, 32'h44, 1, 32'h041, 32'h041);
        acc_addr.delete(); acc_data.delete();
        emif_ready = 1'b0;
        start_load(12'd16, 12'd16, 32'h44, 22'h040);
        feed_q.delete();
        for (int i = 0; i < 8; i++) feed_q.push_back(32'hC0DE0000 + 32'(i));
        feed(ok);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                cfg_h_pix = 12'd1; cfg_v_pix = 12'd1; cfg_pat_num = 32'h99;
                cfg_base_addr = 22'h777; cfg_start = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
            @(negedge clk);
            vectors++;
            if (emif_write !== 1'b1 || emif_addr !== 22'h041 || emif_wdata !== exp_body || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_body_hold[%0d]: got wr=%b addr=%h rdy=%b data=%h required wr=1 addr=041 rdy=0 data=%h",
                         k, emif_write, emif_addr, in_ready, emif_wdata, exp_body);
            end
            @(posedge clk); #1;
        end
        emif_ready = 1'b1;
        @(posedge clk); #1;
        emif_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (emif_write !== 1'b1 || emif_addr !== 22'h040 || emif_wdata !== exp_hdr || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_header_hold[%0d]: got wr=%b addr=%h rdy=%b data=%h required wr=1 addr=040 rdy=0 data=%h",
                         k, emif_write, emif_addr, in_ready, emif_wdata, exp_hdr);
            end
            @(posedge clk); #1;
        end
        emif_ready = 1'b1;
        wait_done(ok);
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (!ok || acc_addr.size() != 2 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accept: got done=%b writes=%0d pulses=%0d busy=%b required 1,2,1,0",
                     ok, acc_addr.size(), done_cnt - d0, busy);
        end else begin
            vectors++;
            if (acc_addr[0] !== 22'h041 || acc_addr[1] !== 22'h040) begin
                miscompares++;
                $display("FAIL bp_order: got addrs %h,%h required 041,040", acc_addr[0], acc_addr[1]);
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_zero_size;
        int e0 = err_cnt;
        bit busy_seen = 1'b0;
        acc_addr.delete(); acc_data.delete();
        start_load(12'd0, 12'd5, 32'h55, 22'h300);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_err: got err=%b busy=%b required err=1 busy=0", err, busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_err_width: got err=%b required 0", err);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        @(posedge clk); #1;
        vectors++;
        if (acc_addr.size() != 0 || busy_seen || err_cnt - e0 != 1) begin
            miscompares++;
            $display("FAIL zero_quiet: got writes=%0d busy_seen=%b err_pulses=%0d required 0,0,1",
                     acc_addr.size(), busy_seen, err_cnt - e0);
        end
        $display("test_zero_size done");
    endtask

    task automatic test_reset_midload;
        bit ok;
        int d0 = done_cnt;
        logic [255:0] exp_body = {32'hABCDE000, 224'd0};
        logic [255:0] exp_hdr  = hdr(20, 1, 20, 32'h66, 1, 32'h601, 32'h601);
        acc_addr.delete(); acc_data.delete();
        start_load(12'd16, 12'd16, 32'h5A, 22'h500);
        feed_q = {32'h1, 32'h2, 32'h3};
        feed(ok);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (emif_write !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || emif_burst !== 5'd1 ||
            emif_wdata !== 256'd0 || emif_addr !== 22'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got wr=%b rdy=%b busy=%b burst=%0d addr=%h data=%h required reset values",
                     emif_write, in_ready, busy, emif_burst, emif_addr, emif_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (acc_addr.size() != 0 || done_cnt != d0) begin
            miscompares++;
            $display("FAIL midrst_no_header: got writes=%0d done_pulses=%0d required 0,0", acc_addr.size(), done_cnt - d0);
        end
        start_load(12'd20, 12'd1, 32'h66, 22'h600);
        feed_q = {32'hABCDE000};
        feed(ok);
        wait_done(ok);
        vectors++;
        if (!ok || acc_addr.size() != 2) begin
            miscompares++;
            $display("FAIL midrst_reload: got done=%b writes=%0d required done and 2 writes", ok, acc_addr.size());
        end else begin
            vectors++;
            if (acc_addr[0] !== 22'h601 || acc_data[0] !== exp_body || acc_addr[1] !== 22'h600 || acc_data[1] !== exp_hdr) begin
                miscompares++;
                $display("FAIL midrst_data: got %h/%h %h/%h required 601/%h 600/%h",
                         acc_addr[0], acc_data[0], acc_addr[1], acc_data[1], exp_body, exp_hdr);
            end
        end
        $display("test_reset_midload done");
    endtask

    initial begin
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_h_pix     = '0;
        cfg_v_pix     = '0;
        cfg_pat_num   = '0;
        cfg_base_addr = '0;
        in_data       = '0;
        in_valid      = 1'b0;
        emif_ready    = 1'b1;
        test_reset();
        test_single_word();
        test_partial();
        test_two_words();
        test_backpressure();
        test_zero_size();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_ddr3_loader.md
Name: pattern_ddr3_loader

Overview:
- Upstream feeder of the pattern fetch/send stage. Takes a 1-bit-per-pixel pattern as a 32-bit word stream and packs it into 256-bit DDR3 words.
- Writes the pattern body and then a 256-bit pattern header into DDR3 through the EMIF Avalon-MM write port. Single clock domain: ddr_emif_clk.
- The header is written last, so a reader never sees a valid header before the body is complete.

Parameters:
- ADDR_W, 22, DDR3 word address width.
- DATA_W, 256, EMIF data width; fixed at 256.

Ports:
- ddr_emif_clk  in  1  EMIF user clock; the only clock.
- ddr_emif_rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; latches the cfg_* inputs and starts a load. Ignored while busy.
- cfg_h_pix  in  12  pattern width in pixels.
- cfg_v_pix  in  12  pattern height in pixels.
- cfg_pat_num  in  32  pattern index, copied into the header.
- cfg_base_addr  in  22  header address; the body starts at base+1.
- in_data  in  32  pixel bits, MSB = earliest pixel; 1 = black.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle.
- ddr_emif_ready  in  1  EMIF ready (inverse of waitrequest).
- ddr_emif_write  out  1  write request.
- ddr_emif_read  out  1  tied 0.
- ddr_emif_addr  out  22  write address.
- ddr_emif_write_data  out  256  write data.
- ddr_emif_byte_enable  out  32  all ones whenever ddr_emif_write is high.
- ddr_emif_burst_count  out  5  constant 1.
- busy  out  1  high from the cycle after cfg_start until done.
- done  out  1  one-cycle pulse when the header write is accepted.
- err  out  1  one-cycle pulse when a zero-size pattern is rejected.

Behaviour:

Reset:
- All outputs are 0 except ddr_emif_burst_count = 1.
- State returns to IDLE; the pack register and all counters clear.
- Reset asserted mid-load abandons the load. A partial body may remain in DDR3, but no header is written.

Transfer and arithmetic rules:
- An EMIF write is accepted when ddr_emif_write && ddr_emif_ready.
- While ddr_emif_write is high and ready is low, addr and write_data are held stable.
- An input word transfers when in_valid && in_ready.
- total_pix = h*v, unsigned 24-bit, zero-extended to 32 bits.
- in_words = ceil(total_pix/32).
- body_words = ceil(total_pix/256).
- Address arithmetic wraps modulo 2^22.

Packing:
- Within a 256-bit word, the first input word lands in [255:224], the next in [223:192], and so on.
- Unused low bits of the final partial 32-bit word are zero.
- Unfilled slots of the final 256-bit word are zero.
- The input stream carries exactly in_words words. Excess words are not accepted, because in_ready stays low outside BODY_FILL.

State machine:
- IDLE: in_ready = 0.
  - On cfg_start, latch cfg_*. If h==0 or v==0, pulse err the next cycle and stay in IDLE. Otherwise go to CALC.
- CALC, 1 cycle: compute total_pix, in_words and body_words. Set wr_addr = base+1 and slot = 0. Go to BODY_FILL.
- BODY_FILL: in_ready = 1.
  - Each accepted word goes into the current slot; slot increments and the remaining-word count decrements.
  - Go to BODY_WR when slot 7 is filled or the last input word is accepted.
- BODY_WR: in_ready = 0; ddr_emif_write = 1 at wr_addr.
  - On accept: wr_addr increments, the pack register clears and slot = 0.
  - Go to HEADER_WR if all words have been written, else back to BODY_FILL.
  - Latency: a write is asserted on the cycle after its last slot is filled.
- HEADER_WR: write at base with data {h_pix, v_pix, total_pix, pat_num, fill_size=body_words, start_addr=base+1, end_addr=base+body_words, rsv=0}.
  - Each field is 32 bits, MSB-first; 12/22-bit quantities are zero-extended.
  - On accept, pulse done and go to IDLE.
- cfg_start asserted in any non-IDLE state is ignored.

Test Plan:
- h=16, v=16, base=0x100, words 0xA5A5A5A5 then 0x00000000..0x00000006, ready=1 -> 8 words accepted; one body write at 0x101 with data {A5A5A5A5,0,1,...,6}; header at 0x100 with total_pix=256, fill_size=1, start=0x101, end=0x101; done pulse.
- h=20, v=1, word 0xFFFFF000 -> one body write at base+1 with data = 0xFFFFF000 in [255:224] and zeros elsewhere; header total_pix=20.
- h=32, v=9 (288 px, 9 words) -> body writes at base+1 (8 words) and base+2 (1 word + zeros); header fill_size=2, end=base+2.
- ddr_emif_ready held low for 5 cycles during BODY_WR and HEADER_WR -> addr and data held stable; in_ready=0; exactly one write accepted each.
- h=0, v=5 with cfg_start -> err pulse one cycle later, no EMIF writes, busy stays 0.
- ddr_emif_rst asserted after 3 body words -> all outputs return to reset values, no header write; a fresh cfg_start runs a full load to completion.
